// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: latches two endpoints on start and streams every pixel of the
// segment over a valid/ready interface, suppressing pixels that fall outside the active area.
module line_rasterizer #(
   parameter int HOR_ACTIVE_PIXELS = 640,
   parameter int VER_ACTIVE_PIXELS = 480,
   localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
   localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               ready,
   input  logic [X_WIDTH-1:0] x1,
   input  logic [Y_WIDTH-1:0] y1,
   input  logic [X_WIDTH-1:0] x2,
   input  logic [Y_WIDTH-1:0] y2,
   output logic [X_WIDTH-1:0] pixel_x,
   output logic [Y_WIDTH-1:0] pixel_y,
   output logic               pixel_valid,
   input  logic               pixel_ready
);

   localparam int E_WIDTH = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2;
   localparam logic [X_WIDTH:0] HorLim = (X_WIDTH + 1)'(HOR_ACTIVE_PIXELS);
   localparam logic [Y_WIDTH:0] VerLim = (Y_WIDTH + 1)'(VER_ACTIVE_PIXELS);

   typedef enum logic [1:0] {StIdle, StSetup, StStep} state_e;

   state_e                     state_q, state_d;
   logic [X_WIDTH-1:0]         cur_x_q, cur_x_d, end_x_q, end_x_d;
   logic [Y_WIDTH-1:0]         cur_y_q, cur_y_d, end_y_q, end_y_d;
   logic signed [E_WIDTH-1:0]  dx_q, dx_d, dy_q, dy_d, err_q, err_d;
   logic                       sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

   logic signed [E_WIDTH-1:0]  diff_x, diff_y, abs_x, abs_y;
   logic signed [E_WIDTH:0]    e2, dx_ext, dy_ext;
   logic                       on_screen, advance, at_end, step_x, step_y;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cur_x_q  <= '0;
         cur_y_q  <= '0;
         end_x_q  <= '0;
         end_y_q  <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         err_q    <= '0;
         sx_neg_q <= 1'b0;
         sy_neg_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cur_x_q  <= cur_x_d;
         cur_y_q  <= cur_y_d;
         end_x_q  <= end_x_d;
         end_y_q  <= end_y_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         err_q    <= err_d;
         sx_neg_q <= sx_neg_d;
         sy_neg_q <= sy_neg_d;
      end
   end

   // Endpoint deltas; cur holds (x1,y1) while in setup.
   always_comb begin
      diff_x = $signed({{(E_WIDTH - X_WIDTH){1'b0}}, end_x_q})
             - $signed({{(E_WIDTH - X_WIDTH){1'b0}}, cur_x_q});
      diff_y = $signed({{(E_WIDTH - Y_WIDTH){1'b0}}, end_y_q})
             - $signed({{(E_WIDTH - Y_WIDTH){1'b0}}, cur_y_q});
      abs_x  = diff_x[E_WIDTH-1] ? -diff_x : diff_x;
      abs_y  = diff_y[E_WIDTH-1] ? -diff_y : diff_y;
   end

   always_comb begin
      e2        = {err_q, 1'b0};
      dx_ext    = {dx_q[E_WIDTH-1], dx_q};
      dy_ext    = {dy_q[E_WIDTH-1], dy_q};
      step_x    = (e2 >= dy_ext);
      step_y    = (e2 <= dx_ext);
      on_screen = ({1'b0, cur_x_q} < HorLim) && ({1'b0, cur_y_q} < VerLim);
      at_end    = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);
      // Clipped pixels never wait on the framebuffer.
      advance   = !on_screen || pixel_ready;
   end

   always_comb begin
      state_d  = state_q;
      cur_x_d  = cur_x_q;
      cur_y_d  = cur_y_q;
      end_x_d  = end_x_q;
      end_y_d  = end_y_q;
      dx_d     = dx_q;
      dy_d     = dy_q;
      err_d    = err_q;
      sx_neg_d = sx_neg_q;
      sy_neg_d = sy_neg_q;
      ready       = 1'b0;
      pixel_valid = 1'b0;

      unique case (state_q)
         StIdle: begin
            ready = 1'b1;
            if (start) begin
               cur_x_d = x1;
               cur_y_d = y1;
               end_x_d = x2;
               end_y_d = y2;
               state_d = StSetup;
            end
         end
         StSetup: begin
            dx_d     = abs_x;
            dy_d     = -abs_y;
            err_d    = abs_x - abs_y;
            sx_neg_d = diff_x[E_WIDTH-1];
            sy_neg_d = diff_y[E_WIDTH-1];
            state_d  = StStep;
         end
         StStep: begin
            pixel_valid = on_screen;
            if (advance) begin
               if (at_end) begin
                  state_d = StIdle;
               end else begin
                  err_d = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
                  if (step_x) begin
                     cur_x_d = sx_neg_q ? cur_x_q - X_WIDTH'(1) : cur_x_q + X_WIDTH'(1);
                  end
                  if (step_y) begin
                     cur_y_d = sy_neg_q ? cur_y_q - Y_WIDTH'(1) : cur_y_q + Y_WIDTH'(1);
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign pixel_x = cur_x_q;
   assign pixel_y = cur_y_q;

endmodule

// File: tb/tb_line_rasterizer.sv
// Self-checking bench for line_rasterizer: table of lines with a pixel scoreboard, plus
// hand-written sequences for the exact-order, reset-abort and ignored-start cases.
module tb_line_rasterizer;

   localparam int HOR = 640;
   localparam int VER = 480;
   localparam int XW  = $clog2(HOR);
   localparam int YW  = $clog2(VER);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          ready;
   logic [XW-1:0] x1 = '0, x2 = '0;
   logic [YW-1:0] y1 = '0, y2 = '0;
   logic [XW-1:0] pixel_x;
   logic [YW-1:0] pixel_y;
   logic          pixel_valid;
   logic          pixel_ready = 1'b1;

   typedef struct {
      int x;
      int y;
   } pix_t;

   typedef struct {
      int    x1, y1, x2, y2;
      bit    bp;          // pixel_ready low on every other cycle
      bit    hold_start;  // keep start high (with decoy endpoints) through the whole line
      int    exp_busy;    // cycles with ready=0, or -1 when not checked
      int    exp_vis;     // accepted on-screen pixels
      string name;
   } vec_t;

   pix_t exp_q[$];
   vec_t vecs[7];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   line_rasterizer #(
      .HOR_ACTIVE_PIXELS(HOR),
      .VER_ACTIVE_PIXELS(VER)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .ready      (ready),
      .x1         (x1),
      .y1         (y1),
      .x2         (x2),
      .y2         (y2),
      .pixel_x    (pixel_x),
      .pixel_y    (pixel_y),
      .pixel_valid(pixel_valid),
      .pixel_ready(pixel_ready)
   );

   task automatic check(input string name, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   // Reference Bresenham: pushes the on-screen pixels in emission order.
   function automatic void push_model(input int ax, input int ay, input int bx, input int by);
      int dx, dy, sx, sy, err, e2, x, y;
      dx  = (bx > ax) ? bx - ax : ax - bx;
      dy  = (by > ay) ? ay - by : by - ay;
      sx  = (ax < bx) ? 1 : -1;
      sy  = (ay < by) ? 1 : -1;
      err = dx + dy;
      x   = ax;
      y   = ay;
      for (int guard = 0; guard < 4096; guard++) begin
         if (x < HOR && y < VER) exp_q.push_back('{x: x, y: y});
         if (x == bx && y == by) break;
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; x += sx; end
         if (e2 <= dx) begin err += dx; y += sy; end
      end
   endfunction

   // Called at a negedge with ready=1; returns at the negedge where ready is seen high again.
   task automatic run_line(input vec_t v);
      int   busy, vis, first_idx;
      bit   prev_stall, done;
      pix_t prev, got, want;
      check({v.name, " ready before start"}, int'(ready), 1);
      x1 = XW'(v.x1); y1 = YW'(v.y1); x2 = XW'(v.x2); y2 = YW'(v.y2);
      start = 1'b1;
      @(negedge clk);
      if (v.hold_start) begin
         x1 = XW'(100); y1 = YW'(100); x2 = XW'(120); y2 = YW'(101);
      end else begin
         start = 1'b0;
      end
      busy = 0; vis = 0; first_idx = -1; prev_stall = 1'b0; done = 1'b0;
      prev = '{x: 0, y: 0};
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (ready) begin
            done = 1'b1;
            break;
         end
         busy++;
         pixel_ready = v.bp ? ((busy % 2) == 0) : 1'b1;
         got = '{x: int'(pixel_x), y: int'(pixel_y)};
         if (busy == 1) check({v.name, " valid during setup"}, int'(pixel_valid), 0);
         if (pixel_valid && first_idx < 0) first_idx = busy;
         if (prev_stall) begin
            check({v.name, " hold valid"}, int'(pixel_valid), 1);
            check({v.name, " hold xy"}, got.x * 1024 + got.y, prev.x * 1024 + prev.y);
         end
         if (pixel_valid && pixel_ready) begin
            vis++;
            if (exp_q.size() == 0) begin
               check({v.name, " unexpected pixel x*1024+y"}, got.x * 1024 + got.y, -1);
            end else begin
               want = exp_q.pop_front();
               check({v.name, " pixel x*1024+y"}, got.x * 1024 + got.y,
                     want.x * 1024 + want.y);
            end
         end
         prev_stall = pixel_valid && !pixel_ready;
         prev = got;
         @(negedge clk);
      end
      start = 1'b0;
      pixel_ready = 1'b1;
      check({v.name, " finished within budget"}, int'(done), 1);
      if (v.exp_busy >= 0) check({v.name, " busy cycles"}, busy, v.exp_busy);
      check({v.name, " visible pixels"}, vis, v.exp_vis);
      if (v.x1 < HOR && v.y1 < VER) check({v.name, " first pixel latency"}, first_idx, 2);
      check({v.name, " scoreboard drained"}, exp_q.size(), 0);
      exp_q.delete();
      if (v.hold_start) begin
         @(negedge clk);
         check({v.name, " start at finish ignored"}, int'(ready), 1);
      end
   endtask

   initial begin
      vec_t v;
      int   k;
      bit   hit;

      //           x1   y1   x2   y2  bp hs busy vis name
      vecs[0] = '{  5,   5,   5,   5, 0, 0,   2,  1, "T1 point"};
      vecs[1] = '{  0, 240,   3, 240, 0, 0,   5,  4, "T2 horiz"};
      vecs[2] = '{ 10,  10,   8,  15, 1, 0,  -1,  6, "T4 steep bp"};
      vecs[3] = '{638,   0, 641,   0, 0, 0,   5,  2, "T5 xclip"};
      vecs[4] = '{  0,   0,   7,   3, 0, 1,   9,  8, "shallow"};
      vecs[5] = '{  7,   3,   0,   0, 0, 0,   9,  8, "shallow rev"};
      vecs[6] = '{  0, 470,   4, 490, 0, 0,  22, 10, "yclip"};

      #12;
      check("reset ready", int'(ready), 1);
      check("reset valid", int'(pixel_valid), 0);
      check("reset pixel_x", int'(pixel_x), 0);
      check("reset pixel_y", int'(pixel_y), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         push_model(vecs[i].x1, vecs[i].y1, vecs[i].x2, vecs[i].y2);
         run_line(vecs[i]);
      end

      // T3: exact order from hand-derived constants.
      exp_q.push_back('{x: 10, y: 10});
      exp_q.push_back('{x: 10, y: 11});
      exp_q.push_back('{x:  9, y: 12});
      exp_q.push_back('{x:  9, y: 13});
      exp_q.push_back('{x:  8, y: 14});
      exp_q.push_back('{x:  8, y: 15});
      v = '{10, 10, 8, 15, 0, 0, 7, 6, "T3 steep"};
      run_line(v);

      // T6: stray start mid-line, then reset on the 3rd pixel of a long line.
      x1 = '0; y1 = '0; x2 = XW'(100); y2 = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0; hit = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (pixel_valid) begin
            check("T6 pixel x", int'(pixel_x), k);
            if (k == 1) begin
               start = 1'b1; x1 = XW'(50); y1 = YW'(50); x2 = XW'(60); y2 = YW'(50);
            end else begin
               start = 1'b0;
            end
            if (k == 2) begin
               hit = 1'b1;
               break;
            end
            k++;
         end
         @(negedge clk);
      end
      check("T6 reached 3rd pixel", int'(hit), 1);
      start = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("T6 abort valid", int'(pixel_valid), 0);
      check("T6 abort ready", int'(ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int cyc = 0; cyc < 3; cyc++) begin
         @(negedge clk);
         check("T6 quiet after reset", int'(pixel_valid), 0);
      end
      push_model(0, 1, 3, 1);
      v = '{0, 1, 3, 1, 0, 0, 5, 4, "T6 restart"};
      run_line(v);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

endmodule
